bcd_scan_counter: RTL

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_pkg.sv | 15 +
 rtl/bcd_digit.sv | 48 ++++
 rtl/bcd_scan_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared constants and digit type for the four-decade BCD scan counter.
package bcd_scan_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef logic [3:0] bcd_digit_t;

  // Non-decimal nibbles are forced to zero so a decade can never leave 0..9.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: synchronous load, up/down step on carry-in, carry-out on wrap.
module bcd_digit
  import bcd_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       up_dn,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  bcd_digit_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    cout    = 1'b0;
    if (load) begin
      digit_d = bcd_sanitize(load_val);
    end else if (cin) begin
      if (up_dn) begin
        if (digit_q >= BCD_MAX) begin
          digit_d = 4'd0;
          cout    = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == 4'd0) begin
          digit_d = BCD_MAX;
          cout    = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= 4'd0;
    else     digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled tick and multiplexed digit scan.
// Define BCD_SCAN_BLANK_EN to blank leading zero digits (bcd driven to BLANK_CODE).
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up_dn,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        carry,
  output logic [3:0]  bcd,
  output logic [3:0]  dig_sel
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST     = SW'(SCAN_DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [1:0]            idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  tick;
  logic [NUM_DIGITS:0]   chain;

  always_comb begin
    presc_d = presc_q;
    tick    = en && (presc_q == PRESCALE_LAST);
    if (load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == PRESCALE_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  // Load suppresses the tick so a coincident load never also steps the count.
  assign chain[0] = tick & ~load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val[4*g +: 4]),
      .up_dn    (up_dn),
      .cin      (chain[g]),
      .digit    (count[4*g +: 4]),
      .cout     (chain[g+1])
    );
  end

  assign carry_d = ~load & chain[NUM_DIGITS];

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  assign carry   = carry_q;
  assign dig_sel = ~(4'b0001 << idx_q);

  always_comb begin
    bcd = count[{idx_q, 2'b00} +: 4];
`ifdef BCD_SCAN_BLANK_EN
    // Blank when this digit and everything above it is zero; units always shown.
    if ((idx_q != 2'd0) && ((count >> {idx_q, 2'b00}) == 16'h0000)) begin
      bcd = BLANK_CODE;
    end
`endif
  end

endmodule
